// File: rtl/readout_packet_framer.sv
// Buffers sparse (index,data) readout entries in a FIFO and emits framed words
// (header, index/data pairs, XOR trailer) on a valid/ready stream.
module readout_packet_framer #(
  parameter int          ADDR_WIDTH  = 9,
  parameter int          DATA_WIDTH  = 32,
  parameter int          FIFO_AW     = 4,
  parameter int          MAX_ENTRIES = 8,
  parameter logic [7:0]  HEADER_TAG  = 8'hC5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] packetIndex,
  input  logic [DATA_WIDTH-1:0] packetData,
  input  logic                  packetValid,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] txData,
  output logic                  txValid,
  output logic                  txLast,
  input  logic                  txReady,
  output logic [15:0]           dropCount,
  output logic                  overflow
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = FIFO_AW + 1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] idx;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  typedef enum logic [2:0] {IDLE, HEADER, INDEX, DATA, TRAILER} state_t;

  entry_t              mem [DEPTH];
  entry_t              head;
  logic [FIFO_AW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]       count;
  logic                full, push, pop, xfer, start;
  logic [7:0]          n_start, n_reg, rem;
  logic [DATA_WIDTH-1:0] csum;
  logic                flush_pending;
  state_t              state, state_nxt;

  assign full    = (count == CW'(DEPTH));
  // A full FIFO drops the entry even if a pop frees a slot this same cycle.
  assign push    = packetValid && !full;
  assign xfer    = txValid && txReady;
  assign pop     = xfer && (state == DATA);
  assign head    = mem[rd_ptr];
  assign start   = (state == IDLE) &&
                   ((int'(count) >= MAX_ENTRIES) || (flush_pending && (count != '0)));
  assign n_start = (int'(count) >= MAX_ENTRIES) ? 8'(MAX_ENTRIES) : 8'(count);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{idx: packetIndex, data: packetData};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dropCount <= '0;
      overflow  <= 1'b0;
    end else if (packetValid && full) begin
      overflow <= 1'b1;
      if (dropCount != 16'hFFFF) dropCount <= dropCount + 16'd1;
    end
  end

  // A new flush wins over the clear so push+flush in one cycle still frames.
  always_ff @(posedge clk) begin
    if (reset)                                   flush_pending <= 1'b0;
    else if (flush)                              flush_pending <= 1'b1;
    else if (state == IDLE && count == '0)       flush_pending <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      n_reg <= '0;
      rem   <= '0;
      csum  <= '0;
    end else if (start) begin
      n_reg <= n_start;
      rem   <= n_start;
      csum  <= '0;
    end else if (xfer) begin
      if (state != TRAILER) csum <= csum ^ txData;
      if (state == DATA)    rem  <= rem - 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)   state_nxt = HEADER;
      HEADER:  if (txReady) state_nxt = INDEX;
      INDEX:   if (txReady) state_nxt = DATA;
      DATA:    if (txReady) state_nxt = (rem == 8'd1) ? TRAILER : INDEX;
      TRAILER: if (txReady) state_nxt = IDLE;
      default:              state_nxt = IDLE;
    endcase
  end

  // Words are derived from the FIFO head, which only moves on a DATA transfer,
  // so txData stays stable while stalled.
  always_comb begin
    txValid = 1'b0;
    txLast  = 1'b0;
    txData  = '0;
    case (state)
      HEADER: begin
        txValid = 1'b1;
        txData  = {HEADER_TAG, n_reg, 16'(head.idx)};
      end
      INDEX: begin
        txValid = 1'b1;
        txData  = {16'b0, 16'(head.idx)};
      end
      DATA: begin
        txValid = 1'b1;
        txData  = head.data;
      end
      TRAILER: begin
        txValid = 1'b1;
        txLast  = 1'b1;
        txData  = csum;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_readout_packet_framer.sv
// Scoreboard bench for readout_packet_framer: a reference entry queue builds
// expected frames, and a negedge monitor compares every transferred word.
module tb_readout_packet_framer;
  logic        clk = 0;
  logic        reset = 1;
  logic [8:0]  packetIndex = '0;
  logic [31:0] packetData = '0;
  logic        packetValid = 0;
  logic        flush = 0;
  logic [31:0] txData;
  logic        txValid, txLast;
  logic        txReady = 0;
  logic [15:0] dropCount;
  logic        overflow;

  int checks = 0;
  int failures = 0;

  logic [32:0] exp_q[$];
  int          mdl_idx[$];
  logic [31:0] mdl_data[$];

  logic        prev_stall = 0;
  logic [31:0] prev_data = '0;
  logic        prev_last = 0;

  readout_packet_framer dut (
    .clk(clk), .reset(reset), .packetIndex(packetIndex), .packetData(packetData),
    .packetValid(packetValid), .flush(flush), .txData(txData), .txValid(txValid),
    .txLast(txLast), .txReady(txReady), .dropCount(dropCount), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (txValid !== 1'b1 || txData !== prev_data || txLast !== prev_last) begin
          failures++;
          $display("FAIL hold_stable: valid=%b data=%h last=%b, required valid=1 data=%h last=%b",
                   txValid, txData, txLast, prev_data, prev_last);
        end
      end
      if (txValid && txReady) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_word: got data=%h last=%b, no word expected", txData, txLast);
        end else begin
          logic [32:0] e;
          e = exp_q.pop_front();
          if ({txLast, txData} !== e) begin
            failures++;
            $display("FAIL tx_word: got last=%b data=%h, required last=%b data=%h",
                     txLast, txData, e[32], e[31:0]);
          end
        end
      end
      prev_stall = txValid && !txReady;
      prev_data  = txData;
      prev_last  = txLast;
    end
  end

  // Pop n entries from the reference queue and queue the frame they must form.
  task automatic exp_frame(input int n);
    logic [31:0] w, cs;
    int idx;
    w  = {8'hC5, 8'(n), 16'(mdl_idx[0])};
    cs = w;
    exp_q.push_back({1'b0, w});
    for (int i = 0; i < n; i++) begin
      idx = mdl_idx.pop_front();
      w = {16'b0, 16'(idx)};
      cs ^= w;
      exp_q.push_back({1'b0, w});
      w = mdl_data.pop_front();
      cs ^= w;
      exp_q.push_back({1'b0, w});
    end
    exp_q.push_back({1'b1, cs});
  endtask

  task automatic push_entry(input int idx, input logic [31:0] data, input bit fl, input bit keep);
    packetIndex = 9'(idx);
    packetData  = data;
    packetValid = 1;
    flush       = fl;
    if (keep) begin
      mdl_idx.push_back(idx);
      mdl_data.push_back(data);
    end
    @(posedge clk); #1;
    packetValid = 0;
    flush       = 0;
  endtask

  task automatic pulse_flush();
    flush = 1;
    @(posedge clk); #1;
    flush = 0;
  endtask

  task automatic wait_drain(input bit rnd, input int budget, input string name);
    bit done = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (rnd) txReady = 1'($urandom_range(0, 1));
      if (exp_q.size() == 0 && !txValid) begin
        done = 1;
        break;
      end
    end
    txReady = 1;
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL %s_drain: %0d words still expected after %0d cycles, required 0",
               name, exp_q.size(), budget);
    end
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(posedge clk); #1;
    checks++;
    if ({txValid, txLast, txData, dropCount, overflow} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: valid=%b last=%b data=%h drop=%0d ovf=%b, required all 0",
               txValid, txLast, txData, dropCount, overflow);
    end
  endtask

  // Full frame at full rate: 18 words with no bubble between first and last.
  task automatic test_full_frame();
    int first = -1, last = -1, cnt = 0;
    txReady = 1;
    for (int i = 0; i < 8; i++) push_entry(i, 32'(100 + i), 0, 1);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL full_frame_pre: %0d words queued, required 0", exp_q.size());
    end
    exp_frame(8);
    checks++;
    if (exp_q[0] !== {1'b0, 32'hC508_0000}) begin
      failures++;
      $display("FAIL full_frame_hdr_model: %h, required C5080000", exp_q[0][31:0]);
    end
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (txValid) begin
        if (first < 0) first = i;
        last = i;
        cnt++;
      end
    end
    checks++;
    if (cnt != 18 || last - first + 1 != 18) begin
      failures++;
      $display("FAIL full_frame_rate: %0d valid cycles over span %0d, required 18 and 18",
               cnt, last - first + 1);
    end
    wait_drain(0, 20, "full_frame");
  endtask

  task automatic test_flush_partial();
    push_entry(5, 32'hA5A5_0001, 0, 1);
    push_entry(9, 32'h1234_5678, 0, 1);
    push_entry(12, 32'hDEAD_BEEF, 0, 1);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (txValid !== 1'b0) begin
      failures++;
      $display("FAIL partial_no_early_frame: txValid=%b, required 0", txValid);
    end
    exp_frame(3);
    checks++;
    if (exp_q[0][31:0] !== 32'hC503_0005) begin
      failures++;
      $display("FAIL partial_hdr_model: %h, required C5030005", exp_q[0][31:0]);
    end
    pulse_flush();
    wait_drain(0, 40, "flush_partial");
  endtask

  task automatic test_backpressure();
    txReady = 0;
    for (int i = 0; i < 8; i++) push_entry(i, 32'(100 + i), 0, 1);
    exp_frame(8);
    wait_drain(1, 400, "backpressure");
  endtask

  task automatic test_overflow();
    txReady = 0;
    for (int i = 0; i < 20; i++) push_entry(20 + i, 32'(200 + i), 0, i < 16);
    @(posedge clk); #1;
    checks++;
    if (dropCount !== 16'd4 || overflow !== 1'b1) begin
      failures++;
      $display("FAIL overflow_count: drop=%0d ovf=%b, required drop=4 ovf=1", dropCount, overflow);
    end
    exp_frame(8);
    exp_frame(8);
    checks++;
    if (exp_q[18][31:0] !== 32'hC508_001C) begin
      failures++;
      $display("FAIL overflow_hdr2_model: %h, required C508001C", exp_q[18][31:0]);
    end
    txReady = 1;
    pulse_flush();
    wait_drain(0, 100, "overflow");
    checks++;
    if (dropCount !== 16'd4 || overflow !== 1'b1) begin
      failures++;
      $display("FAIL overflow_sticky: drop=%0d ovf=%b, required drop=4 ovf=1", dropCount, overflow);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit seen = 0;
    logic [32:0] full_q[$];
    txReady = 0;
    for (int i = 0; i < 8; i++) push_entry(50 + i, 32'(300 + i), 0, 1);
    exp_frame(8);
    full_q = exp_q;
    exp_q.delete();
    exp_q.push_back(full_q[0]);
    exp_q.push_back(full_q[1]);
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); #1;
      seen = txValid;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL midreset_start: txValid=0 after 20 cycles, required 1");
    end
    txReady = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    txReady = 0;
    @(posedge clk); #1;
    reset = 1;
    mdl_idx.delete();
    mdl_data.delete();
    @(posedge clk); #1;
    reset = 0;
    checks++;
    if ({txValid, txLast, dropCount, overflow} !== '0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL midreset_state: valid=%b last=%b drop=%0d ovf=%b pending=%0d, required all 0",
               txValid, txLast, dropCount, overflow, exp_q.size());
    end
    txReady = 1;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (txValid) seen = 1;
    end
    pulse_flush();
    repeat (5) begin
      @(posedge clk); #1;
      if (txValid) seen = 1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL midreset_fifo_empty: txValid=1 seen, required 0");
    end
    for (int i = 0; i < 8; i++) push_entry(60 + i, 32'(400 + i), 0, 1);
    exp_frame(8);
    wait_drain(0, 40, "midreset_clean");
  endtask

  task automatic test_flush_edges();
    bit seen = 0;
    txReady = 1;
    pulse_flush();
    repeat (10) begin
      @(posedge clk); #1;
      if (txValid) seen = 1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL empty_flush: txValid=1 seen, required 0");
    end
    push_entry(300, 32'hCAFE_F00D, 1, 1);
    exp_frame(1);
    wait_drain(0, 20, "push_flush");
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_flush_partial();
    test_backpressure();
    test_overflow();
    test_reset_mid_frame();
    test_flush_edges();
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
